// File: rtl/mcs4_pkg.sv
// Shared types and helpers for the i4003 chain loader.
// Holds the sequencer state type and counter sizing.
package mcs4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    FIN
  } state_t;

  localparam int DEF_NBITS = 10;
  localparam int DEF_DIV   = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mcs4_sck_timer.sv
// SCK half-period timer: counts DIV clocks per half-period.
// o_expire marks the last clock of each half-period.
module mcs4_sck_timer
  import mcs4_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last   = (r_cnt == LAST);
  assign o_expire = i_en & w_last;

  // wraps on expiry so back-to-back half-periods need no restart
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mcs4_shifter_ctrl.sv
// Serial loader for a chain of i4003 shift registers.
// Shifts a parallel word MSB-first and captures the old chain contents.
module mcs4_shifter_ctrl
  import mcs4_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int DIV   = DEF_DIV,
  parameter bit BLANK = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_res,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [NBITS-1:0] i_load_data,
  input  logic             i_oe_en,
  output logic             o_sck,
  output logic             o_sdi,
  output logic             o_oe,
  input  logic             i_sdo_in,
  output logic [NBITS-1:0] o_capt_data,
  output logic             o_busy,
  output logic             o_done
);

  localparam int BW = clog2(NBITS + 1);
  localparam logic [BW-1:0] BITS = BW'(NBITS);
  localparam logic [BW-1:0] ONE  = BW'(1);

  state_t           r_state;
  state_t           w_next;
  logic [NBITS-1:0] r_shift;
  logic [NBITS-1:0] r_cap;
  logic [NBITS-1:0] r_capt;
  logic [NBITS-1:0] w_shl;
  logic [BW-1:0]    r_bitcnt;
  logic             r_sck;
  logic             r_sdi;
  logic             r_oe;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;
  logic             w_start;
  logic             w_accept;
  logic             w_run;
  logic             w_expire;
  logic             w_busy_nx;

  mcs4_sck_timer #(
    .DIV(DIV)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_res),
    .i_start (w_start),
    .i_en    (w_run),
    .o_expire(w_expire)
  );

  assign w_run     = (r_state == LOW) || (r_state == HIGH);
  assign w_busy_nx = (w_next == LOW) || (w_next == HIGH);
  assign w_shl     = r_shift << 1;

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_load_valid && r_ready) begin
          w_next   = LOW;
          w_start  = 1'b1;
          w_accept = 1'b1;
        end
      end
      LOW: begin
        if (w_expire) w_next = HIGH;
      end
      HIGH: begin
        if (w_expire)
          w_next = (r_bitcnt == ONE) ? FIN : LOW;
      end
      FIN: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_res) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_sck    <= 1'b0;
      r_sdi    <= 1'b0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
      r_capt   <= '0;
      r_cap    <= '0;
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_sck   <= (w_next == HIGH);
      r_busy  <= w_busy_nx;
      r_done  <= (w_next == FIN);
      r_ready <= (w_next == IDLE);
      r_oe    <= i_oe_en & ~(BLANK & w_busy_nx);
      if (w_accept) begin
        r_shift  <= i_load_data;
        r_bitcnt <= BITS;
        r_sdi    <= i_load_data[NBITS-1];
      end
      // sample the chain end just before the rise that shifts it
      if (r_state == LOW && w_expire)
        r_cap <= (r_cap << 1) | NBITS'(i_sdo_in);
      if (r_state == HIGH && w_expire) begin
        r_bitcnt <= r_bitcnt - 1'b1;
        if (w_next == LOW) begin
          r_shift <= w_shl;
          r_sdi   <= w_shl[NBITS-1];
        end
      end
      if (w_next == FIN) r_capt <= r_cap;
    end
  end

  assign o_load_ready = r_ready;
  assign o_sck        = r_sck;
  assign o_sdi        = r_sdi;
  assign o_oe         = r_oe;
  assign o_capt_data  = r_capt;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_mcs4_shifter_ctrl.sv
// Scoreboard bench for the i4003 chain loader.
// Three configurations driven side by side, with behavioural chip models.
`timescale 1ns/1ps
module tb_mcs4_shifter_ctrl;

  localparam int NA = 10;
  localparam int DA = 4;
  localparam int NB = 20;
  localparam int DB = 1;
  localparam int NC = 10;
  localparam int DC = 2;

  typedef struct {
    int          t;
    logic [63:0] capt;
    logic [63:0] q;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // configuration A: one chip, DIV=4, blanking
  logic          res_a = 1'b1;
  logic          va = 1'b0;
  logic          oe_en_a = 1'b1;
  logic [NA-1:0] da = '0;
  logic          ra, sck_a, sdi_a, oe_a, sdo_a, busy_a, done_a;
  logic [NA-1:0] capt_a;

  mcs4_shifter_ctrl #(.NBITS(NA), .DIV(DA), .BLANK(1'b1)) u_a (
    .i_clk(clk), .i_res(res_a), .i_load_valid(va),
    .o_load_ready(ra), .i_load_data(da), .i_oe_en(oe_en_a),
    .o_sck(sck_a), .o_sdi(sdi_a), .o_oe(oe_a), .i_sdo_in(sdo_a),
    .o_capt_data(capt_a), .o_busy(busy_a), .o_done(done_a)
  );

  // configuration B: two chained chips, DIV=1
  logic          res_bc = 1'b1;
  logic          vb = 1'b0;
  logic [NB-1:0] db = '0;
  logic          rb, sck_b, sdi_b, oe_b, sdo_b, busy_b, done_b;
  logic [NB-1:0] capt_b;

  mcs4_shifter_ctrl #(.NBITS(NB), .DIV(DB), .BLANK(1'b1)) u_b (
    .i_clk(clk), .i_res(res_bc), .i_load_valid(vb),
    .o_load_ready(rb), .i_load_data(db), .i_oe_en(1'b1),
    .o_sck(sck_b), .o_sdi(sdi_b), .o_oe(oe_b), .i_sdo_in(sdo_b),
    .o_capt_data(capt_b), .o_busy(busy_b), .o_done(done_b)
  );

  // configuration C: no blanking, continuous loads
  logic          vc = 1'b1;
  logic          oe_en_c = 1'b1;
  logic [NC-1:0] dc = 10'h155;
  logic          rc, sck_c, sdi_c, oe_c, busy_c, done_c;
  logic [NC-1:0] capt_c;

  mcs4_shifter_ctrl #(.NBITS(NC), .DIV(DC), .BLANK(1'b0)) u_c (
    .i_clk(clk), .i_res(res_bc), .i_load_valid(vc),
    .o_load_ready(rc), .i_load_data(dc), .i_oe_en(oe_en_c),
    .o_sck(sck_c), .o_sdi(sdi_c), .o_oe(oe_c), .i_sdo_in(1'b0),
    .o_capt_data(capt_c), .o_busy(busy_c), .o_done(done_c)
  );

  // i4003 chip models
  logic [NA-1:0] qa = '0;
  int            rises_a = 0;
  always @(posedge sck_a) begin
    qa <= {qa[NA-2:0], sdi_a};
    rises_a++;
  end
  assign sdo_a = qa[NA-1];

  logic [9:0] near_b = '0;
  logic [9:0] far_b = '0;
  always @(posedge sck_b) begin
    near_b <= {near_b[8:0], sdi_b};
    far_b  <= {far_b[8:0], near_b[9]};
  end
  assign sdo_b = far_b[9];

  // reference state
  exp_t          sba[$];
  exp_t          sbb[$];
  exp_t          e_a, e_b;
  logic [NA-1:0] ref_a = '0;
  logic [NA-1:0] prev_a = '0;
  logic [NB-1:0] ref_b = '0;
  int            acc_a = 0;
  int            acc_b = 0;
  int            rises_at_acc_a = 0;
  int            done_cyc_a = 0;
  bit            hold_a = 1'b0;
  bit            b2b_a = 1'b0;
  logic          exp_oe_c = 1'b0;

  always @(posedge clk) begin
    if (res_a) begin
      sba.delete();
    end else if (va && ra) begin
      if (b2b_a) begin
        chk("b2b_accept_cycle", 64'(cyc), 64'(done_cyc_a + 1));
        b2b_a = 1'b0;
      end
      sba.push_back('{cyc + 2*DA*NA + 1, 64'(ref_a), 64'(da)});
      prev_a = ref_a;
      ref_a = da;
      rises_at_acc_a = rises_a;
      acc_a++;
    end
    if (res_bc) begin
      sbb.delete();
    end else if (vb && rb) begin
      sbb.push_back('{cyc + 2*DB*NB + 1, 64'(ref_b), 64'(db)});
      ref_b = db;
      acc_b++;
    end
    exp_oe_c = res_bc ? 1'b0 : oe_en_c;
    cyc++;
  end

  always @(negedge clk) begin
    if (!res_a) begin
      if (busy_a) begin
        chk("a_oe_low_busy", 64'(oe_a), 64'(0));
        chk("a_ready_low_busy", 64'(ra), 64'(0));
      end
      if (done_a) begin
        chk("a_done_has_exp", 64'(sba.size() > 0), 64'(1));
        if (sba.size() > 0) begin
          e_a = sba.pop_front();
          chk("a_done_cycle", 64'(cyc), 64'(e_a.t));
          chk("a_capt", 64'(capt_a), e_a.capt);
          chk("a_chain_q", 64'(qa), e_a.q);
          chk("a_sck_rises", 64'(rises_a - rises_at_acc_a), 64'(NA));
          chk("a_oe_fin", 64'(oe_a), 64'(oe_en_a));
        end
        done_cyc_a = cyc;
        if (hold_a && va) b2b_a = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!res_bc && done_b) begin
      chk("b_done_has_exp", 64'(sbb.size() > 0), 64'(1));
      if (sbb.size() > 0) begin
        e_b = sbb.pop_front();
        chk("b_done_cycle", 64'(cyc), 64'(e_b.t));
        chk("b_capt", 64'(capt_b), e_b.capt);
        chk("b_far_q", 64'(far_b), 64'(e_b.q[19:10]));
        chk("b_near_q", 64'(near_b), 64'(e_b.q[9:0]));
      end
    end
    if (cyc > 2) chk("c_oe_track", 64'(oe_c), 64'(exp_oe_c));
  end

  always @(negedge clk) begin
    if ($urandom_range(0, 7) == 0) oe_en_c = ~oe_en_c;
    if (done_c) dc = NC'($urandom);
  end

  task automatic send_a(input logic [NA-1:0] w, input bit keep);
    int n;
    n = acc_a;
    da = w;
    va = 1'b1;
    for (int i = 0; i < 2000 && acc_a == n; i++) @(negedge clk);
    chk("a_accept_wait", 64'(acc_a != n), 64'(1));
    if (!keep) va = 1'b0;
  endtask

  task automatic wait_a();
    for (int i = 0; i < 2000 && (sba.size() != 0 || !ra); i++)
      @(negedge clk);
    chk("a_idle_wait", 64'(sba.size()), 64'(0));
  endtask

  task automatic send_b(input logic [NB-1:0] w);
    int n;
    n = acc_b;
    db = w;
    vb = 1'b1;
    for (int i = 0; i < 2000 && acc_b == n; i++) @(negedge clk);
    chk("b_accept_wait", 64'(acc_b != n), 64'(1));
    vb = 1'b0;
    for (int i = 0; i < 2000 && (sbb.size() != 0 || !rb); i++)
      @(negedge clk);
    chk("b_idle_wait", 64'(sbb.size()), 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ra), 64'(1));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_sck", 64'(sck_a), 64'(0));
    chk("rst_sdi", 64'(sdi_a), 64'(0));
    chk("rst_oe", 64'(oe_a), 64'(0));
    chk("rst_done", 64'(done_a), 64'(0));
    chk("rst_capt", 64'(capt_a), 64'(0));
    res_a = 1'b0;
    res_bc = 1'b0;
    @(negedge clk);
    chk("a_oe_idle", 64'(oe_a), 64'(1));

    send_a(10'h2A5, 1'b0);
    wait_a();
    send_a(10'h3FF, 1'b0);
    send_a(10'h001, 1'b0);
    wait_a();

    hold_a = 1'b1;
    for (int k = 0; k < 3; k++) send_a(NA'($urandom), 1'b1);
    send_a(NA'($urandom), 1'b0);
    wait_a();
    hold_a = 1'b0;

    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_a(NA'($urandom), 1'b0);
    end
    wait_a();

    send_a(NA'($urandom), 1'b0);
    for (int i = 0; i < 500 && (rises_a - rises_at_acc_a) < 5; i++)
      @(negedge clk);
    chk("a_rise5_wait", 64'(rises_a - rises_at_acc_a), 64'(5));
    res_a = 1'b1;
    ref_a = (prev_a << 5) | (ref_a >> (NA - 5));
    @(negedge clk);
    res_a = 1'b0;
    chk("mid_rst_sck", 64'(sck_a), 64'(0));
    chk("mid_rst_busy", 64'(busy_a), 64'(0));
    chk("mid_rst_oe", 64'(oe_a), 64'(0));
    chk("mid_rst_capt", 64'(capt_a), 64'(0));
    chk("mid_rst_ready", 64'(ra), 64'(1));
    chk("mid_rst_done", 64'(done_a), 64'(0));
    repeat (2 * DA * NA) @(negedge clk);
    chk("mid_rst_partial_rises", 64'(rises_a - rises_at_acc_a), 64'(5));
    send_a(NA'($urandom), 1'b0);
    wait_a();

    send_b(20'hABCDE);
    for (int k = 0; k < 4; k++) send_b(NB'($urandom));

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
